// File: rtl/fifo_uart_tx_if.sv
// Signal bundle between the TX byte FIFO read port, the UART serializer and status readers.
// master is the serializer side; slave is the FIFO/pin/status side.
interface fifo_uart_tx_if;
    logic        tx_enable;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        serial_out;
    logic        busy;
    logic [15:0] bytes_sent;

    modport master (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output serial_out,
        output busy,
        output bytes_sent
    );

    modport slave (
        output tx_enable,
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  serial_out,
        input  busy,
        input  bytes_sent
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the TX FIFO and sends each as an 8N1 UART frame, LSB first.
// Provides pause control (tx_enable) and a wrapping count of completed frames.
module fifo_uart_tx #(
    parameter int CLOCK_FREQ       = 125_000_000,
    parameter int BAUD_RATE        = 115_200,
    parameter int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE,
    parameter int CNT_WIDTH        = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus
);

    localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [3:0]           LAST_BIT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [9:0]           shift_q,    shift_d;
    logic [3:0]           bit_idx_q,  bit_idx_d;
    logic [CNT_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
    logic                 serial_q,   serial_d;
    logic [15:0]          bytes_sent_q;
    logic                 frame_done;
    logic                 pop;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        frame_done = 1'b0;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                pop = bus.tx_enable && !bus.fifo_empty;
                if (pop) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                // FIFO data is valid this cycle, one cycle after the pop request.
                shift_d    = {1'b1, bus.fifo_dout, 1'b0};
                bit_idx_d  = '0;
                baud_cnt_d = '0;
                state_d    = SEND;
            end

            SEND: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b1, shift_q[9:1]};
                    bit_idx_d  = bit_idx_q + 4'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The line is registered so the pin never sees decode glitches.
        serial_d = (state_d == SEND) ? shift_d[0] : 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            baud_cnt_q   <= '0;
            serial_q     <= 1'b1;
            bytes_sent_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            serial_q   <= serial_d;
            if (frame_done) begin
                bytes_sent_q <= bytes_sent_q + 16'd1;
            end
        end
    end

    // NOTE: the frame shift register is pure datapath and is always loaded in LOAD before SEND reads it, so it carries no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.fifo_rd_en = pop && rst;
    assign bus.serial_out = serial_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized scoreboard bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT,
// pops push expected frames, and an independent line monitor decodes and compares them.
module tb_fifo_uart_tx;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int T          = CLOCK_FREQ / BAUD_RATE;
    localparam int FRAME      = 10 * T;

    typedef struct {
        logic [7:0] data;
        int         rd_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks    = 0;
    int          n_pass      = 0;
    int          cyc         = 0;
    logic [7:0]  fifo_q[$];
    bit          pop_pending = 1'b0;
    exp_t        exp_q[$];
    int          start_log[$];
    int          frames_done = 0;
    int          rd_pulses   = 0;
    bit          prev_rd     = 1'b0;
    bit          low_seen    = 1'b0;
    bit          mon_active  = 1'b0;
    logic [15:0] exp_sent    = 16'd0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO read-port model: data appears after a pop request, the entry leaves one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (pop_pending) begin
            fifo_q.delete(0);
            pop_pending = 1'b0;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        #1;
        if (bus.fifo_rd_en === 1'b1) begin
            rd_pulses++;
            check("rd_en during reset", rst, 1);
            check("rd_en while empty", bus.fifo_empty, 0);
            check("rd_en consecutive", prev_rd, 0);
            check("rd_en while paused", bus.tx_enable, 1);
            if (fifo_q.size() > 0) begin
                bus.fifo_dout = fifo_q[0];
                e.data        = fifo_q[0];
                e.rd_cyc      = cyc;
                exp_q.push_back(e);
                pop_pending   = 1'b1;
            end
        end
        prev_rd = (bus.fifo_rd_en === 1'b1);
        if (bus.serial_out !== 1'b1) low_seen = 1'b1;
    end

    task automatic run_frame();
        exp_t       e;
        logic [9:0] bits;
        logic [7:0] got     = 8'h00;
        int         errs    = 0;
        bit         aborted = 1'b0;
        mon_active = 1'b1;
        start_log.push_back(cyc);
        if (exp_q.size() == 0) begin
            check("frame without pop", 1, 0);
            for (int w = 0; w < FRAME && bus.serial_out !== 1'b1; w++) @(negedge clk);
            mon_active = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        check("start bit latency", cyc, e.rd_cyc + 2);
        bits = {1'b1, e.data, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            if (rst !== 1'b1) begin
                aborted = 1'b1;
                break;
            end
            if (bus.serial_out !== bits[k / T]) errs++;
            if ((k % T) == (T / 2) && (k / T) >= 1 && (k / T) <= 8) got[k / T - 1] = bus.serial_out;
        end
        if (!aborted) begin
            check("frame waveform errors", errs, 0);
            check("decoded byte", got, e.data);
            @(negedge clk);
            exp_sent = exp_sent + 16'd1;
            check("bytes_sent after frame", bus.bytes_sent, exp_sent);
            check("line idle after stop", bus.serial_out, 1);
            frames_done++;
        end
        mon_active = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.serial_out === 1'b0) run_frame();
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (!(fifo_q.size() == 0 && !pop_pending && exp_q.size() == 0 && !mon_active &&
                 bus.busy === 1'b0) && waited < 4000) begin
            step(1);
            waited++;
        end
        check({name, " drain timeout"}, waited < 4000, 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int p0;
        int n0;
        int f0;
        int s;
        int w;

        rst           = 1'b0;
        bus.tx_enable = 1'b1;

        // Reset held with data waiting: no pops, line high, counters clear.
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check("reset rd_en", bus.fifo_rd_en, 0);
            check("reset serial_out", bus.serial_out, 1);
            check("reset busy", bus.busy, 0);
            check("reset bytes_sent", bus.bytes_sent, 0);
        end

        // Single byte 0xA5.
        p0 = rd_pulses;
        step(1);
        rst = 1'b1;
        drain("single");
        step(20);
        check("single rd_en pulses", rd_pulses - p0, 1);
        check("single bytes_sent", bus.bytes_sent, 16'd1);

        // Back-to-back preload.
        p0 = rd_pulses;
        n0 = start_log.size();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        drain("b2b");
        check("b2b frame count", start_log.size() - n0, 3);
        if (start_log.size() - n0 == 3) begin
            for (int i = 0; i < 2; i++) begin
                check("b2b frame spacing", start_log[n0 + i + 1] - start_log[n0 + i], FRAME + 2);
            end
        end
        check("b2b rd_en pulses", rd_pulses - p0, 3);
        check("b2b bytes_sent", bus.bytes_sent, 16'd4);

        // Pause with data waiting, then drop tx_enable mid-frame.
        bus.tx_enable = 1'b0;
        push(8'h11);
        push(8'h22);
        p0       = rd_pulses;
        low_seen = 1'b0;
        step(200);
        check("pause rd_en pulses", rd_pulses - p0, 0);
        check("pause line low seen", low_seen, 0);
        check("pause busy", bus.busy, 0);
        bus.tx_enable = 1'b1;
        for (w = 0; w < 10 && bus.busy !== 1'b1; w++) step(1);
        check("resume busy", bus.busy, 1);
        bus.tx_enable = 1'b0;
        f0 = frames_done;
        for (w = 0; w < 300 && frames_done == f0; w++) step(1);
        check("paused frame completes", frames_done - f0, 1);
        step(50);
        check("pause after frame pulses", rd_pulses - p0, 1);
        check("pause FIFO left", fifo_q.size(), 1);
        bus.tx_enable = 1'b1;
        drain("pause");

        // Reset during data bit 3 of 0x3C; 0x81 waits in the FIFO.
        n0 = start_log.size();
        push(8'h3C);
        push(8'h81);
        for (w = 0; w < 20 && start_log.size() == n0; w++) step(1);
        check("reset-mid frame started", start_log.size() > n0, 1);
        s = (start_log.size() > n0) ? start_log[n0] : cyc;
        while (cyc < s + 4 * T + 3) step(1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset-mid serial_out", bus.serial_out, 1);
        check("reset-mid busy", bus.busy, 0);
        check("reset-mid bytes_sent", bus.bytes_sent, 0);
        exp_sent = 16'd0;
        step(2);
        rst = 1'b1;
        drain("reset-mid");
        check("reset-mid resend count", bus.bytes_sent, 16'd1);

        // Randomized bytes with random arrival gaps.
        for (int i = 0; i < 10; i++) begin
            step($urandom_range(0, 150));
            push(8'($urandom_range(0, 255)));
        end
        drain("random");
        check("random bytes_sent", bus.bytes_sent, 16'd11);

        // Counter wrap from a preset 0xFFFF.
        dut.bytes_sent_q = 16'hFFFF;
        exp_sent         = 16'hFFFF;
        step(1);
        check("wrap preset", bus.bytes_sent, 16'hFFFF);
        push(8'($urandom_range(0, 255)));
        drain("wrap");
        check("wrap bytes_sent", bus.bytes_sent, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
